splitt_pulse_merger: RTL and testbench
======================================

// Module: splitt_pulse_merger
// PURPOSE
//  Clock-domain consumer of a splitter cell's two output pulse streams (out1 -> a, out2 -> b), sampled as one-cycle events.
//  Merges both streams into one serial pulse stream q, at most one pulse per cycle.
//  Coincident pulses are queued in a saturating backlog counter, not dropped as a bare RSFQ merger would drop them.
//  Reports overflow losses; optionally checks a/b arrival skew for splitter verification.
// PARAMETERS
//  CNT_W     4   backlog counter width; capacity BMAX = 2**CNT_W-1 pending pulses
//  DROP_W    8   width of saturating dropped-pulse counter
//  MAX_SKEW  3   max allowed cycles between paired a/b pulses (skew monitor only)
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  a            in   1       pulse event from splitter out1, one cycle wide
//  b            in   1       pulse event from splitter out2, one cycle wide
//  q            out  1       merged pulse, registered
//  backlog      out  CNT_W   pulses pending after this cycle's emission
//  busy         out  1       backlog != 0
//  overflow     out  1       sticky: a pulse was ever lost to saturation
//  drop_cnt     out  DROP_W  saturating count of lost pulses
//  skew_err     out  1       [SKEW_CHECK_EN] sticky pairing/skew violation
//  skew_cyc     out  3       [SKEW_CHECK_EN] skew of last completed pair, cycles
// BEHAVIOUR
//  - Reset: q=0, backlog=0, busy=0, overflow=0, drop_cnt=0, skew_err=0, skew_cyc=0, monitor IDLE.
//    Reset dominates same-cycle a/b: pending pulses discarded, q=0 in the cycle after the reset edge.
//  - Per cycle: n = a+b (0..2); s = backlog+n (CNT_W+1 bits, no wrap).
//    q_next = (s != 0); r = s - q_next.
//  - If r > BMAX: backlog_next = BMAX, overflow <= 1, drop_cnt += (r-BMAX), saturating at all-ones.
//    Otherwise backlog_next = r.
//  - Latency: a lone pulse at cycle t gives q at t+1. a&b at t gives q at t+1 and t+2.
//    Throughput: 1 pulse/cycle; pulses are never reordered or duplicated.
//  - busy is derived combinationally from the backlog register.
//  - Full boundary: at backlog=BMAX, n=1 is absorbed (emit 1, add 1). n=2 loses exactly 1 pulse.
// CONFIGURATION
//  SKEW_CHECK_EN defined: skew monitor FSM instantiated; skew_err/skew_cyc live.
//  - IDLE: a&b -> skew_cyc=0, stay. a only -> WAIT_B, tmr=1. b only -> WAIT_A, tmr=1.
//  - WAIT_B: b -> skew_cyc=tmr, IDLE. a&b -> pair done (skew_cyc=tmr), new WAIT_B, tmr=1.
//    a only -> skew_err=1, restart tmr=1. Neither -> tmr++; tmr>MAX_SKEW -> skew_err=1, IDLE.
//  - WAIT_A: mirror of WAIT_B.
//  - skew_cyc saturates at 7. Monitor never affects q/backlog.
//  SKEW_CHECK_EN undefined: no monitor logic; skew_err and skew_cyc tied to 0.
// STRUCTURE
//  - Package splitt_merge_pkg: skew_state_t enum (IDLE, WAIT_A, WAIT_B); default CNT_W/DROP_W/MAX_SKEW; SKEW_W=3.
//  - Sub-module splitt_skew_monitor (clk, rst, a, b -> skew_err, skew_cyc), generated only under SKEW_CHECK_EN.
//  - Top keeps the backlog/drop datapath.
// TESTING
//  1 rst=1 with a=b=1 -> next cycle q=0, backlog=0, all flags 0.
//  2 a=1 one cycle at t -> q=1 at t+1 only, backlog stays 0. b alone gives the same.
//  3 a=b=1 at t -> q=1 at t+1,t+2; backlog=1 after t, 0 after t+1.
//  4 CNT_W=2, a=b=1 for 5 cycles -> backlog climbs 1,2,3,3,3; overflow=1 at 4th;
//    drop_cnt=2; then q continues 3 more cycles after inputs stop.
//  5 [SKEW_CHECK_EN] a at t, b at t+2 -> skew_cyc=2, skew_err=0. a at t, no b by t+4 -> skew_err=1.
//  6 [SKEW_CHECK_EN] a at t, a at t+1 (no b) -> skew_err=1; q still emits both pulses.

Source files
------------

// File: rtl/splitt_pulse_merger_pkg.sv
// Shared types and defaults for the splitter pulse merger and its skew monitor.
// Combinational only: no latency, no backpressure.
package splitt_merge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_A,
        WAIT_B
    } skew_state_t;

    localparam int DEF_CNT_W    = 4;
    localparam int DEF_DROP_W   = 8;
    localparam int DEF_MAX_SKEW = 3;
    localparam int SKEW_W       = 3;

    function automatic logic [SKEW_W-1:0] sat_inc(input logic [SKEW_W-1:0] v);
        return (&v) ? v : v + SKEW_W'(1);
    endfunction

endpackage

// File: rtl/splitt_pulse_merger_if.sv
// Pulse-event bundle between a splitter cell's outputs and the merger.
// No latency, no backpressure: events are one-cycle pulses.
interface splitt_pulse_merger_if
    import splitt_merge_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DROP_W = DEF_DROP_W
);
    logic              a;
    logic              b;
    logic              q;
    logic [CNT_W-1:0]  backlog;
    logic              busy;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic              skew_err;
    logic [SKEW_W-1:0] skew_cyc;

    modport master (
        output a, b,
        input  q, backlog, busy, overflow, drop_cnt, skew_err, skew_cyc
    );

    modport slave (
        input  a, b,
        output q, backlog, busy, overflow, drop_cnt, skew_err, skew_cyc
    );
endinterface

// File: rtl/splitt_pulse_merger_skew_monitor.sv
// Checks that a/b pulses arrive in pairs within MAX_SKEW cycles; built only with SKEW_CHECK_EN.
// Latency: flags registered one cycle after the deciding pulse; no backpressure, observe-only.
`ifdef SKEW_CHECK_EN
module splitt_skew_monitor
    import splitt_merge_pkg::*;
#(
    parameter int MAX_SKEW = DEF_MAX_SKEW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a,
    input  logic              b,
    output logic              skew_err,
    output logic [SKEW_W-1:0] skew_cyc
);
    localparam logic [SKEW_W-1:0] MAX_V = SKEW_W'(MAX_SKEW);
    localparam logic [SKEW_W-1:0] ONE_V = SKEW_W'(1);

    skew_state_t       state, state_n;
    logic [SKEW_W-1:0] tmr, tmr_n, cyc_n;
    logic              err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            skew_err <= 1'b0;
            skew_cyc <= '0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            skew_err <= err_n;
            skew_cyc <= cyc_n;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        err_n   = skew_err;
        cyc_n   = skew_cyc;
        case (state)
            IDLE: begin
                if (a && b) begin
                    cyc_n = '0;
                end else if (a) begin
                    state_n = WAIT_B;
                    tmr_n   = ONE_V;
                end else if (b) begin
                    state_n = WAIT_A;
                    tmr_n   = ONE_V;
                end
            end
            WAIT_B: begin
                // A coincident a&b closes the pending pair and opens a new one.
                if (b) begin
                    cyc_n   = tmr;
                    tmr_n   = ONE_V;
                    state_n = a ? WAIT_B : IDLE;
                end else if (a) begin
                    err_n = 1'b1;
                    tmr_n = ONE_V;
                end else begin
                    tmr_n = sat_inc(tmr);
                    if (tmr_n > MAX_V) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_A: begin
                if (a) begin
                    cyc_n   = tmr;
                    tmr_n   = ONE_V;
                    state_n = b ? WAIT_A : IDLE;
                end else if (b) begin
                    err_n = 1'b1;
                    tmr_n = ONE_V;
                end else begin
                    tmr_n = sat_inc(tmr);
                    if (tmr_n > MAX_V) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
`endif

// File: rtl/splitt_pulse_merger.sv
// Merges splitter pulse streams a/b into one serial stream q with a saturating backlog; optional SKEW_CHECK_EN monitor.
// Latency: lone pulse -> q next cycle; coincident pulses drain one per cycle. No backpressure: excess beyond BMAX is counted as dropped.
module splitt_pulse_merger
    import splitt_merge_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int DROP_W   = DEF_DROP_W,
    parameter int MAX_SKEW = DEF_MAX_SKEW
) (
    input logic                 clk,
    input logic                 rst,
    splitt_pulse_merger_if.slave bus
);
    localparam logic [CNT_W:0] BMAX_V = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0]  backlog_r;
    logic              q_r;
    logic              ovf_r;
    logic [DROP_W-1:0] drop_r;

    logic [CNT_W:0]    s;
    logic [CNT_W:0]    r;
    logic              q_n;
    logic              sat;

    always_comb begin
        s   = {1'b0, backlog_r} + {{CNT_W{1'b0}}, bus.a} + {{CNT_W{1'b0}}, bus.b};
        q_n = |s;
        r   = s - {{CNT_W{1'b0}}, q_n};
        // r never exceeds BMAX+1, so saturation loses exactly one pulse.
        sat = (r > BMAX_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r       <= 1'b0;
            backlog_r <= '0;
            ovf_r     <= 1'b0;
            drop_r    <= '0;
        end else begin
            q_r <= q_n;
            if (sat) begin
                backlog_r <= BMAX_V[CNT_W-1:0];
                ovf_r     <= 1'b1;
                if (drop_r != {DROP_W{1'b1}})
                    drop_r <= drop_r + DROP_W'(1);
            end else begin
                backlog_r <= r[CNT_W-1:0];
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.backlog  = backlog_r;
    assign bus.busy     = |backlog_r;
    assign bus.overflow = ovf_r;
    assign bus.drop_cnt = drop_r;

`ifdef SKEW_CHECK_EN
    splitt_skew_monitor #(.MAX_SKEW(MAX_SKEW)) u_skew (
        .clk      (clk),
        .rst      (rst),
        .a        (bus.a),
        .b        (bus.b),
        .skew_err (bus.skew_err),
        .skew_cyc (bus.skew_cyc)
    );
`else
    assign bus.skew_err = 1'b0;
    assign bus.skew_cyc = '0;
`endif
endmodule

// File: tb/tb_splitt_pulse_merger.sv
// Scoreboard bench for splitt_pulse_merger: CNT_W=4 and CNT_W=2 instances driven with identical pulses.
module tb_splitt_pulse_merger;
    import splitt_merge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    splitt_pulse_merger_if #(.CNT_W(4), .DROP_W(8)) bus0 ();
    splitt_pulse_merger_if #(.CNT_W(2), .DROP_W(8)) bus1 ();

    splitt_pulse_merger #(.CNT_W(4), .DROP_W(8), .MAX_SKEW(3)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    splitt_pulse_merger #(.CNT_W(2), .DROP_W(8), .MAX_SKEW(3)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic q;
        int   backlog;
        logic ovf;
        int   drop;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;
    int   bl[2]    = '{0, 0};
    int   drp[2]   = '{0, 0};
    bit   ov[2]    = '{0, 0};
    int   in_cnt[2] = '{0, 0};
    int   q_cnt[2]  = '{0, 0};
    int   bmax[2]   = '{15, 3};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input int i, input bit a, input bit b, input bit r, output exp_t e);
        int s, qn, rem;
        if (r) begin
            bl[i] = 0; drp[i] = 0; ov[i] = 0; in_cnt[i] = 0; q_cnt[i] = 0;
            e.q = 1'b0;
        end else begin
            s  = bl[i] + int'(a) + int'(b);
            qn = (s != 0) ? 1 : 0;
            rem = s - qn;
            in_cnt[i] += int'(a) + int'(b);
            if (rem > bmax[i]) begin
                bl[i] = bmax[i];
                ov[i] = 1;
                drp[i] = (drp[i] + rem - bmax[i] > 255) ? 255 : drp[i] + rem - bmax[i];
            end else begin
                bl[i] = rem;
            end
            e.q = logic'(qn);
        end
        e.backlog = bl[i];
        e.ovf     = ov[i];
        e.drop    = drp[i];
    endtask

    task automatic step(input bit a, input bit b, input bit r);
        exp_t e0, e1, g0, g1;
        @(negedge clk);
        rst = r;
        bus0.a = a; bus0.b = b;
        bus1.a = a; bus1.b = b;
        model(0, a, b, r, e0); sb0.push_back(e0);
        model(1, a, b, r, e1); sb1.push_back(e1);
        @(posedge clk);
        #1;
        g0 = sb0.pop_front();
        g1 = sb1.pop_front();
        check_val("q0",        32'(bus0.q),        32'(g0.q));
        check_val("backlog0",  32'(bus0.backlog),  32'(g0.backlog));
        check_val("busy0",     32'(bus0.busy),     32'(g0.backlog != 0));
        check_val("overflow0", 32'(bus0.overflow), 32'(g0.ovf));
        check_val("drop0",     32'(bus0.drop_cnt), 32'(g0.drop));
        check_val("q1",        32'(bus1.q),        32'(g1.q));
        check_val("backlog1",  32'(bus1.backlog),  32'(g1.backlog));
        check_val("busy1",     32'(bus1.busy),     32'(g1.backlog != 0));
        check_val("overflow1", 32'(bus1.overflow), 32'(g1.ovf));
        check_val("drop1",     32'(bus1.drop_cnt), 32'(g1.drop));
        if (!r && bus0.q === 1'b1) q_cnt[0]++;
        if (!r && bus1.q === 1'b1) q_cnt[1]++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int ov_exp[5];
        int bl_exp[5];
        int qn;
        bl_exp = '{1, 2, 3, 3, 3};
        ov_exp = '{0, 0, 0, 1, 1};
        bus0.a = 1'b0; bus0.b = 1'b0;
        bus1.a = 1'b0; bus1.b = 1'b0;

        // Reset dominates coincident pulses
        step(1'b1, 1'b1, 1'b1);
        check_val("rst_q",        32'(bus0.q),        32'd0);
        check_val("rst_backlog",  32'(bus0.backlog),  32'd0);
        check_val("rst_skew_err", 32'(bus0.skew_err), 32'd0);
        check_val("rst_skew_cyc", 32'(bus0.skew_cyc), 32'd0);
        idle(2);

        // Lone pulses on a, then b
        step(1'b1, 1'b0, 1'b0);
        check_val("lone_a_q", 32'(bus0.q), 32'd1);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        check_val("lone_b_q", 32'(bus0.q), 32'd1);
        idle(2);

        // Coincident pair drains over two cycles
        step(1'b1, 1'b1, 1'b0);
        check_val("pair_bl_t", 32'(bus0.backlog), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check_val("pair_q_t2",  32'(bus0.q),       32'd1);
        check_val("pair_bl_t2", 32'(bus0.backlog), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_val("pair_q_t3", 32'(bus0.q), 32'd0);

        // Saturation on the CNT_W=2 instance
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            check_val($sformatf("sat_bl%0d", k),  32'(bus1.backlog),  32'(bl_exp[k]));
            check_val($sformatf("sat_ovf%0d", k), 32'(bus1.overflow), 32'(ov_exp[k]));
        end
        qn = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (bus1.q === 1'b1) qn++;
        end
        check_val("sat_drain_q", 32'(qn), 32'd3);
        check_val("sat_drop",    32'(bus1.drop_cnt), 32'd2);

`ifdef SKEW_CHECK_EN
        // a at t, b at t+2
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_val("skew2_cyc", 32'(bus0.skew_cyc), 32'd2);
        check_val("skew2_err", 32'(bus0.skew_err), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check_val("skew0_cyc", 32'(bus0.skew_cyc), 32'd0);
        // b leads, a at t+3 is still in range
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        check_val("skew3_cyc", 32'(bus0.skew_cyc), 32'd3);
        check_val("skew3_err", 32'(bus0.skew_err), 32'd0);
        // a with no b
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        check_val("tmo_early", 32'(bus0.skew_err), 32'd0);
        idle(2);
        check_val("tmo_err", 32'(bus0.skew_err), 32'd1);
        // a twice without b
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("dbl_a_err", 32'(bus0.skew_err), 32'd1);
        idle(2);
        check_val("dbl_a_qcnt", 32'(q_cnt[0]), 32'd2);
`endif

        // Random traffic, then drain and check pulse conservation
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45, 1'b0);
        idle(20);
        check_val("cons0", 32'(in_cnt[0]), 32'(q_cnt[0] + int'(bus0.drop_cnt) + int'(bus0.backlog)));
        check_val("cons1", 32'(in_cnt[1]), 32'(q_cnt[1] + int'(bus1.drop_cnt) + int'(bus1.backlog)));
`ifndef SKEW_CHECK_EN
        check_val("noskew_err", 32'(bus0.skew_err), 32'd0);
        check_val("noskew_cyc", 32'(bus0.skew_cyc), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
